// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide,
// sign fix-up, then a one-cycle done strobe that writes the HI/LO registers.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]  cnt;
  logic           is_div;
  logic           neg_q;
  logic           neg_r;
  logic           dz_q;
  logic [W-1:0]   opa;
  logic [W-1:0]   rs_raw;
  logic [2*W-1:0] acc;

  logic           rs_neg;
  logic           rt_neg;
  logic [W-1:0]   rs_mag;
  logic [W-1:0]   rt_mag;
  logic [W:0]     mul_sum;
  logic [W:0]     rem_sh;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] acc_step;
  logic [2*W-1:0] prod_neg;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_CALC;
      S_CALC: if (cnt == CW'(W - 1)) state_next = S_SIGN;
      S_SIGN: state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand magnitudes; unsigned ops never flag a sign
  always_comb begin
    rs_neg = op[0] & rs[W-1];
    rt_neg = op[0] & rt[W-1];
    rs_mag = rs_neg ? W'(-rs) : rs;
    rt_mag = rt_neg ? W'(-rt) : rt;
  end

  // One iteration: acc holds {upper, multiplier} for multiply, {rem, quo} for divide
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opa} : (W+1)'(0));
    rem_sh   = acc[2*W-1:W-1];
    div_ge   = (rem_sh >= {1'b0, opa});
    div_rem  = W'(rem_sh - {1'b0, opa});
    prod_neg = (2*W)'(-acc);
    if (is_div)
      acc_step = div_ge ? {div_rem, acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};
    else
      acc_step = {mul_sum, acc[W-1:1]};
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_q        <= 1'b0;
      opa         <= '0;
      rs_raw      <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_next == S_CALC) || (state_next == S_SIGN);
      done <= (state_next == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          cnt         <= '0;
          is_div      <= op[1];
          neg_q       <= rs_neg ^ rt_neg;
          neg_r       <= rs_neg;
          dz_q        <= op[1] && (rt == '0);
          rs_raw      <= rs;
          opa         <= op[1] ? rt_mag : rs_mag;
          acc         <= {{W{1'b0}}, (op[1] ? rs_mag : rt_mag)};
          div_by_zero <= 1'b0;
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        S_SIGN: begin
          if (dz_q) begin
            hi          <= rs_raw;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            lo <= neg_q ? W'(-acc[W-1:0])     : acc[W-1:0];
            hi <= neg_r ? W'(-acc[2*W-1:W])   : acc[2*W-1:W];
          end else begin
            {hi, lo} <= neg_q ? prod_neg : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against a plain-arithmetic model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;
  logic        prev_dz = 1'b0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS semantics straight from 64-bit integer arithmetic
  function automatic void model(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint sa, sb;
    logic [63:0] p;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (opc)
      2'b00: p = {32'h0, a} * {32'h0, b};
      2'b01: p = 64'(sa * sb);
      2'b10: if (b == 0) begin dz = 1'b1; p = {a, 32'hFFFFFFFF}; end
             else p = {a % b, a / b};
      default: if (b == 0) begin dz = 1'b1; p = {a, 32'hFFFFFFFF}; end
               else p = {32'(sa % sb), 32'(sa / sb)};
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Called at a negedge; returns at the negedge after E+34 so a back-to-back start lands on E+35
  task automatic run_op(input string tag, input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic edz;
    model(opc, a, b, eh, el, edz);
    start = 1'b1; op = opc; rs = a; rt = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); rs = $urandom; rt = $urandom;
    for (int c = 0; c < 33; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == 3);
      if (c == 0) chk({tag, " dz_clear"}, 32'(div_by_zero), 32'h0);
      if (c == 0 || c == 16 || c == 32) begin
        chk({tag, " busy"}, 32'(busy), 32'h1);
        chk({tag, " done_early"}, 32'(done), 32'h0);
        chk({tag, " hi_hold"}, hi, prev_hi);
        chk({tag, " lo_hold"}, lo, prev_lo);
      end else if (busy !== 1'b1 || done !== 1'b0) begin
        chk({tag, " busy_run"}, {30'h0, busy, done}, 32'h2);
      end
    end
    @(negedge clk);
    chk({tag, " done"}, 32'(done), 32'h1);
    chk({tag, " busy_off"}, 32'(busy), 32'h0);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    chk({tag, " dz"}, 32'(div_by_zero), 32'(edz));
    @(negedge clk);
    chk({tag, " done_width"}, 32'(done), 32'h0);
    prev_hi = eh; prev_lo = el; prev_dz = edz;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset dz", 32'(div_by_zero), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max hi_const", prev_hi, 32'hFFFFFFFE);
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'h00000007);
    chk("mult_neg lo_const", prev_lo, 32'hFFFFFFEB);
    run_op("mult_zero", 2'b01, 32'h00000000, 32'h9ABC1234);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'h00000002);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7);
    run_op("divu_zero", 2'b10, 32'h00000064, 32'h0);
    run_op("div_zero_clear", 2'b11, 32'h00000010, 32'h00000003);
    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF);
    run_op("div_zero_s", 2'b11, 32'hFFFF0000, 32'h0);

    // Reset during CALC iteration 10: outputs clear at once, no done follows
    start = 1'b1; op = 2'b00; rs = 32'h12345678; rt = 32'h9ABCDEF0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset hi", hi, 32'h0);
    chk("midreset lo", lo, 32'h0);
    chk("midreset dz", 32'(div_by_zero), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset no_done", 32'(done), 32'h0);
    end
    reset = 1'b1;
    prev_hi = '0; prev_lo = '0; prev_dz = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0) chk("postreset no_done", 32'(done), 32'h0);
    end
    run_op("after_reset", 2'b01, 32'h7FFFFFFF, 32'h80000000);

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1, 2:    rb = 32'($urandom_range(1, 50));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
